// File: rtl/stream_comparator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stream_comparator: registered signed/unsigned comparator with saturating |
// | gt/lt/eq tallies and a stable-streak detector.  Revision: 1.0            |
// +--------------------------------------------------------------------------+
module stream_comparator #(
  parameter int WIDTH      = 16,
  parameter int CNT_WIDTH  = 8,
  parameter int STREAK_LEN = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 in_valid,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  output logic                 gt,
  output logic                 lt,
  output logic                 eq,
  output logic [CNT_WIDTH-1:0] gt_cnt,
  output logic [CNT_WIDTH-1:0] lt_cnt,
  output logic [CNT_WIDTH-1:0] eq_cnt,
  output logic                 stable
);

  typedef enum logic [1:0] {
    RES_NONE = 2'd0,
    RES_GT   = 2'd1,
    RES_LT   = 2'd2,
    RES_EQ   = 2'd3
  } res_e;

  localparam logic [CNT_WIDTH-1:0] c_cnt_max    = '1;
  localparam logic [CNT_WIDTH-1:0] c_streak_len = CNT_WIDTH'(STREAK_LEN);
  localparam logic [CNT_WIDTH-1:0] c_one        = CNT_WIDTH'(1);

  logic                 out_valid_q, out_valid_d;
  logic                 gt_q, gt_d, lt_q, lt_d, eq_q, eq_d;
  logic [CNT_WIDTH-1:0] gt_cnt_q, gt_cnt_d;
  logic [CNT_WIDTH-1:0] lt_cnt_q, lt_cnt_d;
  logic [CNT_WIDTH-1:0] eq_cnt_q, eq_cnt_d;
  logic [CNT_WIDTH-1:0] streak_q, streak_d;
  logic                 stable_q, stable_d;
  res_e                 last_res_q, last_res_d;

  logic w_gt, w_lt;
  res_e w_res;

  always_comb begin
    w_gt = 1'b0;
    w_lt = 1'b0;
    if (signed_mode) begin
      w_gt = $signed(a) > $signed(b);
      w_lt = $signed(a) < $signed(b);
    end else begin
      w_gt = a > b;
      w_lt = a < b;
    end
    w_res = w_gt ? RES_GT : (w_lt ? RES_LT : RES_EQ);
  end

  always_comb begin
    out_valid_d = in_valid;
    gt_d        = gt_q;
    lt_d        = lt_q;
    eq_d        = eq_q;
    gt_cnt_d    = gt_cnt_q;
    lt_cnt_d    = lt_cnt_q;
    eq_cnt_d    = eq_cnt_q;
    streak_d    = streak_q;
    stable_d    = stable_q;
    last_res_d  = last_res_q;

    if (in_valid) begin
      gt_d = (w_res == RES_GT);
      lt_d = (w_res == RES_LT);
      eq_d = (w_res == RES_EQ);
    end

    // Clear discards the tally/streak contribution of a same-cycle sample.
    if (clear) begin
      gt_cnt_d   = '0;
      lt_cnt_d   = '0;
      eq_cnt_d   = '0;
      streak_d   = '0;
      stable_d   = 1'b0;
      last_res_d = RES_NONE;
    end else if (in_valid) begin
      case (w_res)
        RES_GT:  if (gt_cnt_q != c_cnt_max) gt_cnt_d = gt_cnt_q + c_one;
        RES_LT:  if (lt_cnt_q != c_cnt_max) lt_cnt_d = lt_cnt_q + c_one;
        default: if (eq_cnt_q != c_cnt_max) eq_cnt_d = eq_cnt_q + c_one;
      endcase
      if (last_res_q == w_res) begin
        streak_d = (streak_q >= c_streak_len) ? c_streak_len : streak_q + c_one;
      end else begin
        last_res_d = w_res;
        streak_d   = c_one;
      end
      stable_d = (streak_d >= c_streak_len);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      gt_q        <= 1'b0;
      lt_q        <= 1'b0;
      eq_q        <= 1'b0;
      gt_cnt_q    <= '0;
      lt_cnt_q    <= '0;
      eq_cnt_q    <= '0;
      streak_q    <= '0;
      stable_q    <= 1'b0;
      last_res_q  <= RES_NONE;
    end else begin
      out_valid_q <= out_valid_d;
      gt_q        <= gt_d;
      lt_q        <= lt_d;
      eq_q        <= eq_d;
      gt_cnt_q    <= gt_cnt_d;
      lt_cnt_q    <= lt_cnt_d;
      eq_cnt_q    <= eq_cnt_d;
      streak_q    <= streak_d;
      stable_q    <= stable_d;
      last_res_q  <= last_res_d;
    end
  end

  assign out_valid = out_valid_q;
  assign gt        = gt_q;
  assign lt        = lt_q;
  assign eq        = eq_q;
  assign gt_cnt    = gt_cnt_q;
  assign lt_cnt    = lt_cnt_q;
  assign eq_cnt    = eq_cnt_q;
  assign stable    = stable_q;

endmodule
`default_nettype wire
